// File: rtl/diff_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module   : diff_avg_filter
//  Purpose  : Decimating second-difference filter followed by a moving average.
//             Every DECIM-th accepted sample is kept and shifted into a 3-tap
//             line. d = x0 - 2*x1 + x2 is formed from the taps. The last
//             2^AVG_LOG2 differences are averaged with a running sum over a
//             circular buffer.
//  Ports    : CLK       - clock, rising edge
//             RST       - synchronous reset, active-high
//             IN_VALID  - IN carries a sample this cycle
//             IN        - signed DW-bit input sample
//             OUT       - signed DW+2-bit window average (registered, held)
//             OUT_VALID - one-cycle pulse, OUT updated
//             FULL      - window holds 2^AVG_LOG2 valid differences
//  Revision : 1.0 - initial release
// ============================================================================
module diff_avg_filter #(
    parameter int DW       = 8,
    parameter int DECIM    = 64,
    parameter int AVG_LOG2 = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic signed [DW-1:0] IN,
    output logic signed [DW+1:0] OUT,
    output logic                 OUT_VALID,
    output logic                 FULL
);

    localparam int c_depth = 1 << AVG_LOG2;
    localparam int c_cnt_w = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_sum_w = DW + 2 + AVG_LOG2;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DECIM - 1);
    localparam logic [AVG_LOG2-1:0] c_wr_last  = '1;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_emit;
    logic                       w_to_run;

    logic [c_cnt_w-1:0]         r_cnt;
    logic                       w_keep;
    logic                       r_kept;
    logic signed [DW-1:0]       r_x0, r_x1, r_x2;
    logic [1:0]                 r_taps;

    logic signed [DW+1:0]       w_x0e, w_x1e, w_x2e, w_d;
    logic signed [DW+1:0]       r_d;
    logic                       r_dvld;

    logic signed [DW+1:0]       r_buf [c_depth];
    logic [AVG_LOG2-1:0]        r_wr;
    logic signed [c_sum_w-1:0]  r_sum;
    logic signed [c_sum_w-1:0]  w_d_ext, w_old_ext, w_sum_next;
    logic signed [DW+1:0]       w_avg;

    assign w_keep = IN_VALID && (r_cnt == c_cnt_last);

    // The true result fits in DW+2 bits, so modular arithmetic at that width is exact.
    assign w_x0e = {{2{r_x0[DW-1]}}, r_x0};
    assign w_x1e = {{2{r_x1[DW-1]}}, r_x1};
    assign w_x2e = {{2{r_x2[DW-1]}}, r_x2};
    assign w_d   = w_x0e - (w_x1e + w_x1e) + w_x2e;

    // Oldest window entry is read before it is overwritten on the same edge.
    assign w_d_ext    = {{AVG_LOG2{r_d[DW+1]}}, r_d};
    assign w_old_ext  = {{AVG_LOG2{r_buf[r_wr][DW+1]}}, r_buf[r_wr]};
    assign w_sum_next = (r_state == S_RUN) ? (r_sum + w_d_ext - w_old_ext)
                                           : (r_sum + w_d_ext);
    // Dropping the low AVG_LOG2 bits is an arithmetic shift (floor toward -inf).
    assign w_avg      = w_sum_next[c_sum_w-1:AVG_LOG2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_to_run     = 1'b0;
        case (r_state)
            S_PRIME: begin
                if (r_dvld) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (r_dvld && (r_wr == c_wr_last)) begin
                    w_state_next = S_RUN;
                    w_emit       = 1'b1;
                    w_to_run     = 1'b1;
                end
            end
            S_RUN: begin
                w_emit = r_dvld;
            end
            default: begin
                w_state_next = S_PRIME;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_kept    <= 1'b0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_taps    <= 2'd0;
            r_d       <= '0;
            r_dvld    <= 1'b0;
            r_wr      <= '0;
            r_sum     <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            FULL      <= 1'b0;
        end else begin
            if (IN_VALID) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);
            end
            r_kept <= w_keep;
            if (w_keep) begin
                r_x0 <= IN;
                r_x1 <= r_x0;
                r_x2 <= r_x1;
                if (r_taps != 2'd3) begin
                    r_taps <= r_taps + 2'd1;
                end
            end
            // r_taps here already reflects the shift of the kept sample.
            r_d       <= w_d;
            r_dvld    <= r_kept && (r_taps == 2'd3);
            OUT_VALID <= w_emit;
            if (r_dvld) begin
                r_wr  <= r_wr + AVG_LOG2'(1);
                r_sum <= w_sum_next;
            end
            if (w_emit) begin
                OUT <= w_avg;
            end
            if (w_to_run) begin
                FULL <= 1'b1;
            end
        end
    end

    // Window storage has no reset; entries are only read once they are written.
    always_ff @(posedge CLK) begin
        if (!RST && r_dvld) begin
            r_buf[r_wr] <= r_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_diff_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_diff_avg_filter
//  Purpose  : Self-checking bench for diff_avg_filter. Four instances cover the
//             parameter sets of interest; a queue-based reference model gives
//             expected pulses and averages with their two-edge latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_diff_avg_filter;

    logic                clk;
    logic                rst;
    logic [3:0]          iv;
    logic signed [7:0]   din  [4];
    logic signed [9:0]   dout [4];
    logic [3:0]          ov;
    logic [3:0]          fu;

    int errors = 0;
    int checks = 0;

    // instance 0: DECIM=1 N=4, 1: DECIM=4 N=4, 2: DECIM=1 N=2, 3: DECIM=3 N=4
    diff_avg_filter #(.DW(8), .DECIM(1), .AVG_LOG2(2)) u_a (
        .CLK(clk), .RST(rst), .IN_VALID(iv[0]), .IN(din[0]),
        .OUT(dout[0]), .OUT_VALID(ov[0]), .FULL(fu[0]));
    diff_avg_filter #(.DW(8), .DECIM(4), .AVG_LOG2(2)) u_b (
        .CLK(clk), .RST(rst), .IN_VALID(iv[1]), .IN(din[1]),
        .OUT(dout[1]), .OUT_VALID(ov[1]), .FULL(fu[1]));
    diff_avg_filter #(.DW(8), .DECIM(1), .AVG_LOG2(1)) u_c (
        .CLK(clk), .RST(rst), .IN_VALID(iv[2]), .IN(din[2]),
        .OUT(dout[2]), .OUT_VALID(ov[2]), .FULL(fu[2]));
    diff_avg_filter #(.DW(8), .DECIM(3), .AVG_LOG2(2)) u_d (
        .CLK(clk), .RST(rst), .IN_VALID(iv[3]), .IN(din[3]),
        .OUT(dout[3]), .OUT_VALID(ov[3]), .FULL(fu[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int cur;
    int m_decim, m_n, m_vcnt;
    int m_k[$];
    int m_d[$];
    bit e1, e2, exp_v, exp_full;
    int v1, v2, exp_out;

    function automatic int floordiv(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic void model_reset();
        m_vcnt = 0;
        m_k.delete();
        m_d.delete();
    endfunction

    function automatic void model_push(input int x, output bit emit, output int val);
        int sum;
        emit = 1'b0;
        val  = 0;
        m_vcnt++;
        if ((m_vcnt % m_decim) != 0) return;
        m_k.push_back(x);
        if (m_k.size() < 3) return;
        m_d.push_back(m_k[m_k.size()-1] - 2 * m_k[m_k.size()-2] + m_k[m_k.size()-3]);
        if (m_d.size() < m_n) return;
        sum = 0;
        for (int i = 0; i < m_n; i++) sum += m_d[m_d.size()-1-i];
        val  = floordiv(sum, m_n);
        emit = 1'b1;
    endfunction

    function automatic void select(input int idx);
        cur = idx;
        case (idx)
            0: begin m_decim = 1; m_n = 4; end
            1: begin m_decim = 4; m_n = 4; end
            2: begin m_decim = 1; m_n = 2; end
            default: begin m_decim = 3; m_n = 4; end
        endcase
        model_reset();
        e1 = 0; e2 = 0; v1 = 0; v2 = 0;
        exp_v = 0; exp_out = 0; exp_full = 0;
    endfunction

    // Drives one edge on the active instance and advances the expectations.
    task automatic tick(input bit r, input bit v, input int x);
        bit en;
        int nv;
        rst     = r;
        iv      = '0;
        iv[cur] = v;
        din[cur] = 8'(x);
        @(posedge clk);
        #1;
        exp_v = e2;
        if (e2) begin
            exp_out  = v2;
            exp_full = 1'b1;
        end
        en = 1'b0;
        nv = 0;
        if (r) begin
            model_reset();
            e1 = 0; exp_v = 0; exp_out = 0; exp_full = 0;
        end else if (v) begin
            model_push(x, en, nv);
        end
        e2 = e1; v2 = v1;
        e1 = en; v1 = nv;
        rst = 1'b0;
        iv  = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rst = 1'b1;
            iv  = 4'($urandom);
            for (int j = 0; j < 4; j++) din[j] = 8'($urandom);
            @(posedge clk);
            #1;
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (ov[j] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_out_valid inst=%0d got=%b exp=0", j, ov[j]);
                end
                checks++;
                if (dout[j] !== 10'sd0) begin
                    errors++;
                    $display("FAIL reset_out inst=%0d got=%0d exp=0", j, dout[j]);
                end
                checks++;
                if (fu[j] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_full inst=%0d got=%b exp=0", j, fu[j]);
                end
            end
        end
        rst = 1'b0;
        iv  = '0;
    endtask

    task automatic test_impulse();
        int seq[8] = '{0, 0, 0, 0, 100, 0, 0, 0};
        int obs[$];
        int first = -1;
        select(0);
        for (int e = 1; e <= 11; e++) begin
            if (e <= 8) tick(0, 1, seq[e-1]);
            else        tick(0, 0, 0);
            checks++;
            if (ov[cur] !== exp_v) begin
                errors++;
                $display("FAIL impulse_valid edge=%0d got=%b exp=%b", e, ov[cur], exp_v);
            end
            checks++;
            if (dout[cur] !== 10'(exp_out)) begin
                errors++;
                $display("FAIL impulse_out edge=%0d got=%0d exp=%0d", e, dout[cur], exp_out);
            end
            checks++;
            if (fu[cur] !== exp_full) begin
                errors++;
                $display("FAIL impulse_full edge=%0d got=%b exp=%b", e, fu[cur], exp_full);
            end
            if (ov[cur] === 1'b1) begin
                obs.push_back(int'(dout[cur]));
                if (first < 0) first = e;
            end
        end
        checks++;
        if (first != 8) begin
            errors++;
            $display("FAIL impulse_latency got=%0d exp=8", first);
        end
        checks++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL impulse_count got=%0d exp=3", obs.size());
        end else begin
            checks++;
            if (obs[0] != -25 || obs[1] != 0 || obs[2] != 0) begin
                errors++;
                $display("FAIL impulse_values got=%0d,%0d,%0d exp=-25,0,0", obs[0], obs[1], obs[2]);
            end
        end
    endtask

    task automatic test_ramp_decim();
        int first = -1;
        select(1);
        for (int e = 1; e <= 68; e++) begin
            if (e <= 64) tick(0, 1, e - 1);
            else         tick(0, 0, 0);
            checks++;
            if (ov[cur] !== exp_v) begin
                errors++;
                $display("FAIL ramp_valid edge=%0d got=%b exp=%b", e, ov[cur], exp_v);
            end
            checks++;
            if (dout[cur] !== 10'(exp_out)) begin
                errors++;
                $display("FAIL ramp_out edge=%0d got=%0d exp=%0d", e, dout[cur], exp_out);
            end
            checks++;
            if (fu[cur] !== exp_full) begin
                errors++;
                $display("FAIL ramp_full edge=%0d got=%b exp=%b", e, fu[cur], exp_full);
            end
            if (ov[cur] === 1'b1 && first < 0) first = e;
        end
        // sample 23 is applied at edge 24
        checks++;
        if (first != 26) begin
            errors++;
            $display("FAIL ramp_latency got=%0d exp=26", first);
        end
    endtask

    task automatic test_extremes();
        int x;
        int pulses = 0;
        select(2);
        for (int e = 1; e <= 84; e++) begin
            if (e <= 40)      x = (e % 2) ? -128 : 127;
            else if (e <= 80) begin
                case ($urandom_range(0, 3))
                    0: x = -128;
                    1: x = 127;
                    2: x = -127;
                    default: x = int'($urandom_range(0, 255)) - 128;
                endcase
            end
            if (e <= 80) tick(0, 1, x);
            else         tick(0, 0, 0);
            checks++;
            if (ov[cur] !== exp_v) begin
                errors++;
                $display("FAIL extreme_valid edge=%0d got=%b exp=%b", e, ov[cur], exp_v);
            end
            checks++;
            if (dout[cur] !== 10'(exp_out)) begin
                errors++;
                $display("FAIL extreme_out edge=%0d got=%0d exp=%0d", e, dout[cur], exp_out);
            end
            checks++;
            if (fu[cur] !== exp_full) begin
                errors++;
                $display("FAIL extreme_full edge=%0d got=%b exp=%b", e, fu[cur], exp_full);
            end
            if (ov[cur] === 1'b1) pulses++;
        end
        // 80 samples -> 78 differences -> 77 averages with N=2
        checks++;
        if (pulses != 77) begin
            errors++;
            $display("FAIL extreme_pulse_count got=%0d exp=77", pulses);
        end
    endtask

    task automatic test_gaps();
        int vals[$];
        int obs1[$];
        int obs2[$];
        bit v;
        int x;
        select(3);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) tick(1, 0, 0);
            for (int e = 0; e < 124; e++) begin
                if (pass == 0 && e < 120) begin
                    v = bit'($urandom_range(0, 1));
                    x = int'($urandom_range(0, 255)) - 128;
                    if (v) vals.push_back(x);
                    tick(0, v, x);
                end else if (pass == 1 && e < vals.size()) begin
                    tick(0, 1, vals[e]);
                end else if (pass == 1 && e >= vals.size() + 4) begin
                    break;
                end else begin
                    tick(0, 0, 0);
                end
                checks++;
                if (ov[cur] !== exp_v) begin
                    errors++;
                    $display("FAIL gaps_valid pass=%0d cyc=%0d got=%b exp=%b", pass, e, ov[cur], exp_v);
                end
                checks++;
                if (dout[cur] !== 10'(exp_out)) begin
                    errors++;
                    $display("FAIL gaps_out pass=%0d cyc=%0d got=%0d exp=%0d", pass, e, dout[cur], exp_out);
                end
                if (ov[cur] === 1'b1) begin
                    if (pass == 0) obs1.push_back(int'(dout[cur]));
                    else           obs2.push_back(int'(dout[cur]));
                end
            end
        end
        checks++;
        if (obs1.size() != obs2.size()) begin
            errors++;
            $display("FAIL gaps_seq_len got=%0d exp=%0d", obs1.size(), obs2.size());
        end else begin
            for (int i = 0; i < obs1.size(); i++) begin
                checks++;
                if (obs1[i] != obs2[i]) begin
                    errors++;
                    $display("FAIL gaps_seq idx=%0d got=%0d exp=%0d", i, obs1[i], obs2[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        int pulses = 0;
        select(0);
        for (int e = 0; e < 12; e++) tick(0, 1, int'($urandom_range(0, 255)) - 128);
        checks++;
        if (fu[cur] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_full got=%b exp=1", fu[cur]);
        end
        tick(1, 1, 77);
        checks++;
        if (ov[cur] !== 1'b0 || dout[cur] !== 10'sd0 || fu[cur] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got=%b/%0d/%b exp=0/0/0", ov[cur], dout[cur], fu[cur]);
        end
        for (int e = 1; e <= 10; e++) begin
            if (e <= 6) tick(0, 1, int'($urandom_range(0, 255)) - 128);
            else        tick(0, 0, 0);
            checks++;
            if (ov[cur] !== exp_v) begin
                errors++;
                $display("FAIL midrst_valid edge=%0d got=%b exp=%b", e, ov[cur], exp_v);
            end
            checks++;
            if (dout[cur] !== 10'(exp_out)) begin
                errors++;
                $display("FAIL midrst_out edge=%0d got=%0d exp=%0d", e, dout[cur], exp_out);
            end
            if (ov[cur] === 1'b1) begin
                pulses++;
                if (first < 0) first = e;
            end
        end
        checks++;
        if (first != 8 || pulses != 1) begin
            errors++;
            $display("FAIL midrst_restart first=%0d pulses=%0d exp first=8 pulses=1", first, pulses);
        end
    endtask

    task automatic test_back_to_back();
        int run = 0;
        for (int e = 1; e <= 44; e++) begin
            if (e <= 40) tick(0, 1, int'($urandom_range(0, 255)) - 128);
            else         tick(0, 0, 0);
            checks++;
            if (ov[cur] !== exp_v) begin
                errors++;
                $display("FAIL b2b_valid edge=%0d got=%b exp=%b", e, ov[cur], exp_v);
            end
            checks++;
            if (dout[cur] !== 10'(exp_out)) begin
                errors++;
                $display("FAIL b2b_out edge=%0d got=%0d exp=%0d", e, dout[cur], exp_out);
            end
            if (e >= 3 && e <= 42 && ov[cur] === 1'b1) run++;
        end
        // already in RUN: one average per input, 40 inputs
        checks++;
        if (run != 40) begin
            errors++;
            $display("FAIL b2b_throughput got=%0d exp=40", run);
        end
    endtask

    initial begin
        rst = 1'b1;
        iv  = '0;
        for (int j = 0; j < 4; j++) din[j] = '0;
        cur = 0;
        select(0);
        #1;
        test_reset();
        test_impulse();
        test_ramp_decim();
        test_extremes();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
